// File: rtl/rg_word_gen.sv
// -----------------------------------------------------------------------------
// rg_word_gen
//
// Random word generator built around an RG_LEN-bit feedback ring with entropy
// injection. While iEn is high the ring advances every cycle. After WARMUP
// enabled cycles the generator collects ring bit 0 once per cycle, LSB first,
// into OUT_W-bit words. It offers each completed word to a one-entry output
// register.
//
// Optional feature (macro RG_HEALTH_EN):
//   Defined     -> a repetition-count test runs on the collected bit stream.
//                  A run of RCT_LIMIT equal bits sets the sticky oHealthFail
//                  and blocks all further word offers until reset.
//   Not defined -> oHealthFail is tied to 0 and no run counter is built.
//
// Ports:
//   iClk        in   1      clock, all state changes on the rising edge
//   iRstn       in   1      asynchronous active-low reset
//   iEn         in   1      run enable; low returns the FSM to IDLE
//   iEntropy    in   ENT_W  raw entropy, bit k lands on ring bit k*(RG_LEN/ENT_W)
//   iReady      in   1      consumer accepts oData
//   oData       out  OUT_W  assembled random word
//   oValid      out  1      oData holds an unconsumed word
//   oOverflow   out  1      sticky: a completed word was dropped
//   oHealthFail out  1      sticky: repetition-count test failed
//   oSerial     out  1      ring bit 0
//   oDbgState   out  2      FSM state (0 IDLE, 1 WARMUP, 2 COLLECT)
//
// Handshake: oValid/iReady follow strict valid/ready rules.
//   - A word transfers on every rising edge where oValid=1 and iReady=1.
//   - While oValid=1 and iReady=0, oData holds its value.
//   - The generator cannot stall. A word that completes while the register
//     is full and not being consumed is dropped, and oOverflow is set.
// -----------------------------------------------------------------------------
module rg_word_gen #(
  parameter int                RG_LEN    = 16,
  parameter logic [RG_LEN-1:0] FB_MASK   = 16'hB400,
  parameter int                ENT_W     = 8,
  parameter int                OUT_W     = 8,
  parameter int                WARMUP    = 32,
  parameter int                RCT_LIMIT = 24
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iEn,
  input  logic [ENT_W-1:0] iEntropy,
  input  logic             iReady,
  output logic [OUT_W-1:0] oData,
  output logic             oValid,
  output logic             oOverflow,
  output logic             oHealthFail,
  output logic             oSerial,
  output logic [1:0]       oDbgState
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WARMUP  = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;

  localparam int STRIDE = RG_LEN / ENT_W;
  localparam int WC_W   = 10;
  localparam int BC_W   = $clog2(OUT_W);

  logic [RG_LEN-1:0] ring_q, ring_d;
  logic [1:0]        state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [RG_LEN-1:0] ent_vec;
  logic [OUT_W-1:0]  offer_word;
  logic              offer_raw;
  logic              offer;

  // Spread the entropy bits evenly around the ring.
  always_comb begin
    ent_vec = '0;
    for (int k = 0; k < ENT_W; k++) begin
      ent_vec[k*STRIDE] = iEntropy[k];
    end
  end

  // The ring rotates toward bit 0. Bit 0 wraps to the top, and when bit 0
  // is set it is also XORed into every tap position.
  always_comb begin
    ring_d = ring_q;
    if (iEn) begin
      ring_d = {ring_q[0], ring_q[RG_LEN-1:1]}
             ^ (FB_MASK & {RG_LEN{ring_q[0]}})
             ^ ent_vec;
    end
  end

  // Sequencing. The first enabled cycle seen in IDLE already counts as
  // warm-up cycle 0, so collection starts on enabled cycle WARMUP.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    offer_raw  = 1'b0;
    offer_word = word_q;
    offer_word[bcnt_q] = ring_q[0];

    if (!iEn) begin
      // The ring and the output register are left untouched here.
      state_d = ST_IDLE;
      wcnt_d  = '0;
      bcnt_d  = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WARMUP: begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WC_W'(WARMUP - 1)) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_WARMUP;
          end
        end
        ST_COLLECT: begin
          if (bcnt_q == BC_W'(OUT_W - 1)) begin
            offer_raw = 1'b1;
            bcnt_d    = '0;
            word_d    = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
            word_d = offer_word;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef RG_HEALTH_EN
  logic [7:0] run_q, run_d;
  logic       prev_q, prev_d;
  logic       hf_q, hf_d;

  // run_q = 0 means no bit of the current collection stretch has been seen
  // yet. The counter saturates at the limit.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    hf_d   = hf_q;
    if (!iEn) begin
      run_d = '0;
    end else if (state_q == ST_COLLECT) begin
      prev_d = ring_q[0];
      if ((run_q != '0) && (ring_q[0] == prev_q)) begin
        run_d = (run_q == 8'(RCT_LIMIT)) ? run_q : run_q + 1'b1;
      end else begin
        run_d = 8'd1;
      end
      if (run_d == 8'(RCT_LIMIT)) begin
        hf_d = 1'b1;
      end
    end
  end

  // The word that completes on the failing cycle is already suppressed.
  assign offer = offer_raw & ~hf_d;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      run_q  <= '0;
      prev_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
      hf_q   <= hf_d;
    end
  end

  assign oHealthFail = hf_q;
`else
  assign offer       = offer_raw;
  assign oHealthFail = 1'b0;
`endif

  // One-entry output register.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (offer) begin
      if (!valid_q || iReady) begin
        data_d  = offer_word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      ring_q  <= '0;
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ring_q  <= ring_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oData     = data_q;
  assign oValid    = valid_q;
  assign oOverflow = ovf_q;
  assign oSerial   = ring_q[0];
  assign oDbgState = state_q;

endmodule
